fifo_bit_drainer: RTL and testbench

//  Consumer end of the 8-bit byte FIFO's read interface. Watches the FIFO condition flags and

---
 rtl/trivium_pkg.sv | 16 +
 rtl/byte_piso.sv | 28 ++
 rtl/fifo_bit_drainer.sv | 103 ++++++++++
 tb/tb_fifo_bit_drainer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trivium_pkg.sv
// rtl/trivium_pkg.sv - shared FIFO condition codes and drainer state encoding
package trivium_pkg;

   localparam logic [1:0] COND_EMPTY = 2'b00;
   localparam logic [1:0] COND_PART  = 2'b10;
   localparam logic [1:0] COND_FULL  = 2'b11;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT_STB,
      CAPTURE,
      SHIFT
   } drainer_state_t;

endpackage

// File: rtl/byte_piso.sv
// rtl/byte_piso.sv - 8-bit parallel-load / serial-out shift register
module byte_piso #(
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_load,
   input  logic       i_shift,
   input  logic [7:0] i_data,
   output logic       o_bit
);

   logic [7:0] r_sr;

   // load wins over shift so a flush-clear can never be overridden by a handshake
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sr <= 8'h00;
      end else if (i_load) begin
         r_sr <= i_data;
      end else if (i_shift) begin
         r_sr <= MSB_FIRST ? {r_sr[6:0], 1'b0} : {1'b0, r_sr[7:1]};
      end
   end

   assign o_bit = MSB_FIRST ? r_sr[7] : r_sr[0];

endmodule

// File: rtl/fifo_bit_drainer.sv
// rtl/fifo_bit_drainer.sv - pulls bytes from the byte FIFO and serializes them with frame tracking
module fifo_bit_drainer
   import trivium_pkg::*;
#(
   parameter int FRAME_LEN   = 16,
   parameter bit MSB_FIRST   = 1'b1,
   parameter int STB_TIMEOUT = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] fifo_condition,
   input  logic       fifo_read_stb,
   input  logic [7:0] fifo_dout,
   output logic       fifo_read,
   input  logic       flush,
   output logic       bit_out,
   output logic       bit_valid,
   input  logic       bit_ready,
   output logic       frame_last,
   output logic [7:0] byte_cnt,
   output logic       busy
);

   localparam logic [7:0] LAST_BYTE = 8'(FRAME_LEN - 1);
   localparam logic [7:0] TO_LAST   = 8'(STB_TIMEOUT - 1);

   drainer_state_t r_state, w_next;
   logic [7:0] r_to_cnt;
   logic [2:0] r_bit_cnt;
   logic [7:0] r_byte_cnt;
   logic       w_hs;
   logic       w_last_bit;
   logic       w_load;
   logic [7:0] w_load_data;

   assign fifo_read   = (r_state == REQ) && !flush;
   assign bit_valid   = (r_state == SHIFT) && !flush;
   assign w_hs        = bit_valid && bit_ready;
   assign w_last_bit  = (r_bit_cnt == 3'd7);
   assign frame_last  = bit_valid && w_last_bit && (r_byte_cnt == LAST_BYTE);
   assign busy        = (r_state != IDLE);
   assign byte_cnt    = r_byte_cnt;

   // flush reloads the shifter with zeros so the abandoned byte cannot leak out later
   assign w_load      = flush || (r_state == CAPTURE);
   assign w_load_data = flush ? 8'h00 : fifo_dout;

   byte_piso #(.MSB_FIRST(MSB_FIRST)) u_piso (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_load),
      .i_shift (w_hs),
      .i_data  (w_load_data),
      .o_bit   (bit_out)
   );

   always_comb begin
      w_next = r_state;
      if (flush) begin
         w_next = IDLE;
      end else begin
         case (r_state)
            IDLE:     if (fifo_condition != COND_EMPTY) w_next = REQ;
            REQ:      w_next = WAIT_STB;
            WAIT_STB: begin
               if (fifo_read_stb)           w_next = CAPTURE;
               else if (r_to_cnt == TO_LAST) w_next = IDLE;
            end
            CAPTURE:  w_next = SHIFT;
            SHIFT:    if (w_hs && w_last_bit) w_next = IDLE;
            default:  w_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_to_cnt   <= 8'd0;
         r_bit_cnt  <= 3'd0;
         r_byte_cnt <= 8'd0;
      end else begin
         r_state <= w_next;
         if (r_state == REQ) begin
            r_to_cnt <= 8'd0;
         end else if (r_state == WAIT_STB) begin
            r_to_cnt <= r_to_cnt + 8'd1;
         end
         if (flush) begin
            r_bit_cnt  <= 3'd0;
            r_byte_cnt <= 8'd0;
         end else if (r_state == CAPTURE) begin
            r_bit_cnt <= 3'd0;
         end else if (w_hs) begin
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (w_last_bit) begin
               r_byte_cnt <= (r_byte_cnt == LAST_BYTE) ? 8'd0 : r_byte_cnt + 8'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_fifo_bit_drainer.sv
// tb/tb_fifo_bit_drainer.sv - directed self-checking bench for fifo_bit_drainer
module tb_fifo_bit_drainer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] fifo_condition = 2'b00;
   logic       fifo_read_stb = 1'b0;
   logic [7:0] fifo_dout = 8'h00;
   logic       fifo_read;
   logic       flush = 1'b0;
   logic       bit_out;
   logic       bit_valid;
   logic       bit_ready = 1'b0;
   logic       frame_last;
   logic [7:0] byte_cnt;
   logic       busy;

   int         checks = 0;
   int         failures = 0;
   logic       stb_en = 1'b1;
   logic       rd_d1 = 1'b0;
   logic       stb_d1 = 1'b0;
   logic [7:0] next_byte = 8'h00;
   int         b2b = 0;

   always #5 clk = ~clk;

   fifo_bit_drainer #(
      .FRAME_LEN   (2),
      .MSB_FIRST   (1'b1),
      .STB_TIMEOUT (2)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .fifo_condition (fifo_condition),
      .fifo_read_stb  (fifo_read_stb),
      .fifo_dout      (fifo_dout),
      .fifo_read      (fifo_read),
      .flush          (flush),
      .bit_out        (bit_out),
      .bit_valid      (bit_valid),
      .bit_ready      (bit_ready),
      .frame_last     (frame_last),
      .byte_cnt       (byte_cnt),
      .busy           (busy)
   );

   // FIFO model: strobe one cycle after the request, data one cycle after the strobe, junk otherwise
   always @(negedge clk) begin
      if (fifo_read && rd_d1) b2b = b2b + 1;
      fifo_read_stb = rd_d1 && stb_en;
      fifo_dout     = stb_d1 ? next_byte : ~next_byte;
      rd_d1         = fifo_read;
      stb_d1        = fifo_read_stb;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_read(input string tag);
      int n = 0;
      while (fifo_read !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      chk(tag, 32'(fifo_read), 32'd1);
   endtask

   task automatic wait_valid(input string tag);
      int n = 0;
      while (bit_valid !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      chk(tag, 32'(bit_valid), 32'd1);
   endtask

   task automatic do_byte(input logic [7:0] b, input logic fl_last, input string tag);
      logic [7:0] e;
      e = b;
      next_byte = b;
      fifo_condition = 2'b10;
      wait_read({tag, "_read"});
      fifo_condition = 2'b00;
      wait_valid({tag, "_valid"});
      for (int i = 0; i < 8; i++) begin
         chk({tag, "_bit"}, 32'(bit_out), 32'(e[7]));
         chk({tag, "_frame_last"}, 32'(frame_last), 32'(fl_last && (i == 7)));
         e = e << 1;
         step();
      end
   endtask

   initial begin
      logic [7:0] e;
      logic [7:0] col;
      logic       prev_bit, prev_fl, stalled;
      int         hs;

      // reset state
      #2;
      chk("rst_fifo_read", 32'(fifo_read), 32'd0);
      chk("rst_bit_valid", 32'(bit_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_byte_cnt", 32'(byte_cnt), 32'd0);
      chk("rst_bit_out", 32'(bit_out), 32'd0);
      chk("rst_frame_last", 32'(frame_last), 32'd0);
      step();
      step();
      rst = 1'b0;

      // 1: empty FIFO issues nothing
      for (int c = 0; c < 20; c++) begin
         step();
         chk("t1_fifo_read", 32'(fifo_read), 32'd0);
         chk("t1_busy", 32'(busy), 32'd0);
         chk("t1_bit_valid", 32'(bit_valid), 32'd0);
      end

      // 2: single byte, exact latency
      bit_ready = 1'b1;
      next_byte = 8'hA5;
      fifo_condition = 2'b10;
      wait_read("t2_read");
      fifo_condition = 2'b00;
      step();
      chk("t2_stb", 32'(fifo_read_stb), 32'd1);
      chk("t2_read_pulse", 32'(fifo_read), 32'd0);
      step();
      chk("t2_capture_valid", 32'(bit_valid), 32'd0);
      chk("t2_capture_busy", 32'(busy), 32'd1);
      step();
      e = 8'hA5;
      for (int i = 0; i < 8; i++) begin
         chk("t2_valid", 32'(bit_valid), 32'd1);
         chk("t2_bit", 32'(bit_out), 32'(e[7]));
         chk("t2_frame_last", 32'(frame_last), 32'd0);
         e = e << 1;
         step();
      end
      chk("t2_done_valid", 32'(bit_valid), 32'd0);
      chk("t2_done_busy", 32'(busy), 32'd0);
      chk("t2_byte_cnt", 32'(byte_cnt), 32'd1);

      // 3: same byte with bit_ready toggling
      next_byte = 8'hA5;
      fifo_condition = 2'b10;
      wait_read("t3_read");
      fifo_condition = 2'b00;
      bit_ready = 1'b0;
      hs = 0;
      col = 8'h00;
      stalled = 1'b0;
      prev_bit = 1'b0;
      prev_fl = 1'b0;
      for (int c = 0; c < 40; c++) begin
         step();
         if (bit_valid === 1'b1) begin
            if (stalled) begin
               chk("t3_hold_bit", 32'(bit_out), 32'(prev_bit));
               chk("t3_hold_frame_last", 32'(frame_last), 32'(prev_fl));
            end
            prev_bit = bit_out;
            prev_fl = frame_last;
            bit_ready = ~bit_ready;
            if (bit_ready) begin
               chk("t3_frame_last", 32'(frame_last), 32'(hs == 7));
               col = {col[6:0], bit_out};
               hs++;
               stalled = 1'b0;
            end else begin
               stalled = 1'b1;
            end
         end
      end
      chk("t3_handshakes", 32'(hs), 32'd8);
      chk("t3_byte", 32'(col), 32'hA5);
      chk("t3_byte_cnt", 32'(byte_cnt), 32'd0);
      bit_ready = 1'b1;

      // 4: two-byte frame
      chk("t4_byte_cnt0", 32'(byte_cnt), 32'd0);
      do_byte(8'h01, 1'b0, "t4a");
      chk("t4_byte_cnt1", 32'(byte_cnt), 32'd1);
      do_byte(8'h80, 1'b1, "t4b");
      chk("t4_byte_cnt2", 32'(byte_cnt), 32'd0);

      // 5: strobe withheld -> timeout, then re-request
      stb_en = 1'b0;
      next_byte = 8'h3C;
      fifo_condition = 2'b10;
      wait_read("t5_read");
      step();
      chk("t5_no_stb", 32'(fifo_read_stb), 32'd0);
      chk("t5_busy1", 32'(busy), 32'd1);
      step();
      chk("t5_busy2", 32'(busy), 32'd1);
      chk("t5_no_read2", 32'(fifo_read), 32'd0);
      step();
      chk("t5_idle", 32'(busy), 32'd0);
      chk("t5_no_read3", 32'(fifo_read), 32'd0);
      step();
      chk("t5_rereq", 32'(fifo_read), 32'd1);
      stb_en = 1'b1;
      fifo_condition = 2'b00;
      wait_valid("t5_valid");
      e = 8'h3C;
      for (int i = 0; i < 8; i++) begin
         chk("t5_bit", 32'(bit_out), 32'(e[7]));
         e = e << 1;
         step();
      end
      chk("t5_byte_cnt", 32'(byte_cnt), 32'd1);

      // 6: flush at bit 3, then async reset mid-shift
      next_byte = 8'hFF;
      fifo_condition = 2'b10;
      wait_read("t6_read");
      fifo_condition = 2'b00;
      wait_valid("t6_valid");
      for (int i = 0; i < 3; i++) begin
         chk("t6_bit", 32'(bit_out), 32'd1);
         step();
      end
      flush = 1'b1;
      #1;
      chk("t6_flush_valid", 32'(bit_valid), 32'd0);
      chk("t6_flush_read", 32'(fifo_read), 32'd0);
      step();
      flush = 1'b0;
      #1;
      chk("t6_flush_busy", 32'(busy), 32'd0);
      chk("t6_flush_byte_cnt", 32'(byte_cnt), 32'd0);
      chk("t6_flush_bit_out", 32'(bit_out), 32'd0);
      for (int c = 0; c < 4; c++) begin
         step();
         chk("t6_dropped", 32'(bit_valid), 32'd0);
      end
      fifo_condition = 2'b10;
      wait_read("t6_read2");
      fifo_condition = 2'b00;
      wait_valid("t6_valid2");
      step();
      step();
      #3;
      rst = 1'b1;
      #1;
      chk("t6_rst_read", 32'(fifo_read), 32'd0);
      chk("t6_rst_valid", 32'(bit_valid), 32'd0);
      chk("t6_rst_bit_out", 32'(bit_out), 32'd0);
      chk("t6_rst_frame_last", 32'(frame_last), 32'd0);
      chk("t6_rst_byte_cnt", 32'(byte_cnt), 32'd0);
      chk("t6_rst_busy", 32'(busy), 32'd0);
      step();
      rst = 1'b0;
      step();
      chk("t6_post_busy", 32'(busy), 32'd0);
      chk("t6_post_valid", 32'(bit_valid), 32'd0);

      chk("read_back_to_back", 32'(b2b), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
